async_sram_timed_phy: RTL

ASYNC_SRAM_TIMED_PHY -- requirements
Module: async_sram_timed_phy

---
 rtl/async_sram_timed_phy.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/async_sram_timed_phy.sv
// Timed PHY for an asynchronous SRAM. One request is in flight at a time, and every pad is driven from a flop.
// Reads hold OE_n low for RD_WAIT+1 cycles. Writes run setup, then a WE_n pulse, then hold.
module async_sram_timed_phy #(
    parameter int W_ADDR     = 18,
    parameter int W_DATA     = 16,
    parameter int RD_WAIT    = 1,
    parameter int WR_WAIT    = 1,
    parameter int TURNAROUND = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [W_ADDR-1:0]   req_addr,
    input  logic [W_DATA-1:0]   req_wdata,
    input  logic [W_DATA/8-1:0] req_byte_en,
    output logic                rsp_valid,
    output logic [W_DATA-1:0]   rsp_rdata,
    output logic [W_ADDR-1:0]   sram_addr,
    output logic [W_DATA-1:0]   sram_dq_out,
    output logic [W_DATA-1:0]   sram_dq_oe,
    input  logic [W_DATA-1:0]   sram_dq_in,
    output logic                sram_ce_n,
    output logic                sram_we_n,
    output logic                sram_oe_n,
    output logic [W_DATA/8-1:0] sram_byte_n
);

    localparam int W_BE = W_DATA / 8;
    localparam logic [3:0] RD_LD   = 4'(RD_WAIT);
    localparam logic [3:0] WR_LD   = 4'(WR_WAIT);
    localparam logic [3:0] TURN_LD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

    typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, TURN} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [W_BE-1:0]     byte_en_q, byte_en_d;
    logic [W_ADDR-1:0]   addr_q, addr_d;
    logic [W_DATA-1:0]   dq_out_q, dq_out_d;
    logic [W_DATA-1:0]   dq_oe_q, dq_oe_d;
    logic [W_DATA-1:0]   rdata_q, rdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                ready_q, ready_d;
    logic                ce_n_q, ce_n_d;
    logic                we_n_q, we_n_d;
    logic                oe_n_q, oe_n_d;
    logic [W_BE-1:0]     byte_n_q, byte_n_d;
    logic                wr_active;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_en_d   = byte_en_q;
        addr_d      = addr_q;
        dq_out_d    = dq_out_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d    = req_addr;
                    byte_en_d = req_byte_en;
                    if (req_write) begin
                        dq_out_d = req_wdata;
                        state_d  = WR_SETUP;
                    end else begin
                        state_d = READ;
                        cnt_d   = RD_LD;
                    end
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    rdata_d     = sram_dq_in;
                    rsp_valid_d = 1'b1;
                    if (TURNAROUND == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = TURN;
                        cnt_d   = TURN_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = WR_LD;
            end
            WR_PULSE: begin
                if (cnt_q == 4'd0) state_d = WR_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WR_HOLD: state_d = IDLE;
            TURN: begin
                if (cnt_q == 4'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase

        // Pads are registered, so they are decoded from the state being entered.
        wr_active = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
        ce_n_d    = !(wr_active || (state_d == READ));
        oe_n_d    = (state_d != READ);
        we_n_d    = (state_d != WR_PULSE);
        dq_oe_d   = wr_active ? '1 : '0;
        byte_n_d  = (wr_active || (state_d == READ)) ? ~byte_en_d : '1;
        ready_d   = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            byte_en_q   <= '0;
            addr_q      <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            byte_n_q    <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_en_q   <= byte_en_d;
            addr_q      <= addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
            ce_n_q      <= ce_n_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            byte_n_q    <= byte_n_d;
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_byte_n = byte_n_q;

endmodule
